// File: rtl/aes_key_expander.sv
// AES-128 key schedule: expands one cipher key into 11 round keys, one per
// clock, and keeps all of them for random-order reads by the cipher datapath.
// Optional feature macro: AES_KEYEXP_REVERSE_EN adds the rd_rev port, which
// fetches round keys in decryption order (index 10 - rd_idx).

// Single combinational AES-128 key-expansion round: key -> next round key.
module KeyGeneration (
    input  logic [127:0] key,
    input  logic [3:0]   rc,
    output logic [127:0] keyout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [7:0]  rcon;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key[127:96];
    assign w1 = key[95:64];
    assign w2 = key[63:32];
    assign w3 = key[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};
    assign sub_w3 = {SBOX[rot_w3[31:24]], SBOX[rot_w3[23:16]],
                     SBOX[rot_w3[15:8]],  SBOX[rot_w3[7:0]]};

    // Round constant for this expansion step; unused codes give zero rcon.
    always_comb begin
        rcon = 8'h00;
        case (rc)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp = sub_w3 ^ {rcon, 24'h000000};
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign keyout = {n0, n1, n2, n3};

endmodule

module aes_key_expander (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
`ifdef AES_KEYEXP_REVERSE_EN
    input  logic         rd_rev,
`endif
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    state_t       state_q;
    logic [127:0] rk_q [11];
    logic [127:0] cur_q;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic         key_ready_q;
    logic         busy_q;
    logic         keys_valid_q;
    logic [127:0] rd_key_q;
    logic [127:0] rd_key_d;
    logic [3:0]   rd_sel;
    logic [127:0] keyout;

    KeyGeneration u_keygen (
        .key    (cur_q),
        .rc     (cnt_q),
        .keyout (keyout)
    );

    assign cnt_d = cnt_q + 4'd1;

    // Pick the stored round key for the read port; out-of-range indices read zero.
    always_comb begin
        rd_sel   = rd_idx;
`ifdef AES_KEYEXP_REVERSE_EN
        if (rd_rev) begin
            rd_sel = 4'd10 - rd_idx;
        end
`endif
        rd_key_d = '0;
        if (rd_idx <= 4'd10) begin
            rd_key_d = rk_q[rd_sel];
        end
    end

    // Control FSM, round-key storage and registered read port in one process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            cnt_q        <= '0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_key_q     <= '0;
            for (int i = 0; i < 11; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            rd_key_q <= rd_key_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (key_valid) begin
                        rk_q[0]      <= key_in;
                        cur_q        <= key_in;
                        cnt_q        <= '0;
                        state_q      <= ST_EXPAND;
                        key_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        keys_valid_q <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    rk_q[cnt_d] <= keyout;
                    cur_q       <= keyout;
                    if (cnt_q == 4'd9) begin
                        cnt_q        <= '0;
                        state_q      <= ST_DONE;
                        key_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        keys_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    key_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    keys_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential AES-128 key schedule that accepts a 128-bit cipher key and produces all 11 round keys, one per cycle, using a single instance of the team's combinational `KeyGeneration` round module. It sits directly upstream of the cipher round datapath, which reads round keys from it by index. It stores every round key so the cipher can consume them in any order without re-expanding.

## Interface
- No parameters. AES-128 only: 128-bit key, 10 expansion rounds, 11 round keys.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `key_valid` in 1: `key_in` is valid this cycle.
- `key_in` in 128: cipher key, bit 127 = first byte MSB (FIPS-197 order).
- `key_ready` out 1: block can accept a key; high in IDLE and DONE.
- `busy` out 1: high while in EXPAND.
- `keys_valid` out 1: all 11 round keys are stored and stable.
- `rd_idx` in 4: round-key index to read, 0..10.
- `rd_key` out 128: registered round key for `rd_idx`.
- `rd_rev` in 1: present only with `AES_KEYEXP_REVERSE_EN`; see Configuration.

## Operation
- Storage: `rk[0..10]`, each 128 bits. Working register `cur` (128). Round counter `cnt` (4 bits).
- `KeyGeneration` instance inputs:
  - `key` = `cur`.
  - `rc` = `cnt`.
  - `keyout` is the next round key.
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - `key_ready`=1.
  - On `key_valid`: `rk[0]`←`key_in`, `cur`←`key_in`, `cnt`←0, go to EXPAND.
- EXPAND:
  - `key_ready`=0, `busy`=1.
  - Each cycle: `rk[cnt+1]`←`keyout`, `cur`←`keyout`, `cnt`←`cnt`+1.
  - On the edge that writes `rk[10]` (`cnt`==9): go to DONE, `cnt`←0.
- DONE:
  - `keys_valid`=1, `key_ready`=1.
  - On `key_valid`: same action as IDLE, go to EXPAND. `keys_valid` drops on that same edge.
- `key_valid` while `key_ready`=0 is ignored; there is no queueing. The upstream holds `key_valid` until it sees `key_ready`.
- Read port:
  - `rd_key`←`rk[rd_idx]` every cycle, in every state.
  - `rd_idx` 11..15 returns 128'h0.
  - Reads during EXPAND return partially updated contents. Consumers gate reads on `keys_valid`.
- `rc` never exceeds 9, so the `KeyGeneration` default (zero rcon) branch is never exercised.

## Timing
- Reset values:
  - Outputs: `key_ready`=1, `busy`=0, `keys_valid`=0, `rd_key`=0.
  - Internal: state=IDLE, all `rk`, `cur` and `cnt` = 0.
- Key accepted at edge N:
  - `busy` is high N+1..N+10.
  - `rk[k]` is written at edge N+k.
  - `keys_valid` rises after edge N+10.
  - Latency from accept to `keys_valid` = 10 cycles.
- Read latency is 1 cycle: `rd_idx` sampled at edge M appears on `rd_key` after edge M.
- Back-to-back keys: minimum accept spacing is 11 cycles (accept in DONE is allowed).
- `rst` asserted mid-EXPAND:
  - Immediately returns the block to IDLE with all storage cleared.
  - Partial keys are not retained.
  - Deassertion is synchronized externally; no cycle is lost after the first rising edge.

## Configuration
- `AES_KEYEXP_REVERSE_EN` defined:
  - Port `rd_rev` exists.
  - When `rd_rev`=1 and `rd_idx`≤10, the effective index is 10−`rd_idx`. This is the decryption-order fetch.
  - `rd_idx` 11..15 still returns 0.
- `AES_KEYEXP_REVERSE_EN` undefined: port `rd_rev` is absent and `rd_idx` is used directly.

## Test plan
- Reset check: assert `rst` → `key_ready`=1, `busy`=0, `keys_valid`=0, `rd_key`=0. Reading any index returns 0.
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`:
  - `keys_valid` rises exactly 10 cycles after accept.
  - `rd_idx`=1 → `a0fafe1788542cb123a339392a6c7605`.
  - `rd_idx`=10 → `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `rd_idx`=0 → the key itself.
- Hold `key_valid`=1 with a different key during EXPAND → ignored; the round-10 key still matches the first key.
- In DONE, apply key 128'h0 → `keys_valid` drops on the accept edge. After 10 cycles, `rd_idx`=10 → `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Assert `rst` at the 5th EXPAND cycle → IDLE, `keys_valid`=0, `rd_idx`=3 reads 0. Re-issuing the FIPS key completes normally.
- With `AES_KEYEXP_REVERSE_EN`:
  - `rd_rev`=1, `rd_idx`=0 → `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `rd_idx`=12 → 0.
